capture_sequencer: RTL and testbench
====================================

# capture_sequencer

Sequences the ADC sample FIFO for one oscilloscope acquisition. The sequence is: FIFO clear, pre-trigger fill, sliding-window wait for trigger, post-trigger fill, then a pull-style readout to the display/host consumer. It sits between the ADC sample register and comparator trigger on one side and the `adc_fifo` instance on the other. It owns every `wr_en`/`rd_en`/`rst` strobe of that FIFO and applies the sample-decimation ratio.

## Interface

Parameters:
- `DEPTH`, 1024: FIFO capacity in samples (power of two).
- `PRE_DEPTH`, 256: pre-trigger samples retained; must satisfy 1 ≤ `PRE_DEPTH` < `DEPTH`.
- `OCC_W`, 11: occupancy counter width, at least log2(`DEPTH`)+1.
- `CLR_CYCLES`, 4: number of cycles `fifo_rst` is held.

Ports (clock and reset; one clock, reset asynchronous, active-high):
- `clk` in 1: ADC sample clock (25 MHz domain).
- `rst` in 1: asynchronous active-high reset.
- `arm` in 1: one-cycle pulse that starts an acquisition from IDLE.
- `abort` in 1: one-cycle pulse that cancels any acquisition.
- `single_mode` in 1: 1 = stop in IDLE after readout; 0 = auto re-arm.
- `trig_sig` in 1: comparator output (hysteresis already applied).
- `force_trig` in 1: pulse that triggers unconditionally in WAIT_TRIG.
- `extract_num` in 16: decimation; keep 1 of every `extract_num`+1 samples.
- `fifo_full` in 1: FIFO full flag.
- `fifo_empty` in 1: FIFO empty flag.
- `rd_req` in 1: consumer requests one sample.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_rd_en` out 1: FIFO read strobe.
- `fifo_rst` out 1: FIFO reset.
- `rd_valid` out 1: `fifo_out` holds the requested sample.
- `done` out 1: one-cycle pulse when readout completes.
- `busy` out 1: high whenever state ≠ IDLE.
- `state` out 3: IDLE=0, CLEAR=1, PRE=2, WAIT_TRIG=3, POST=4, READOUT=5.

## Operation

- All outputs are registered. On reset, every output is 0 and state is IDLE. Internal `occ`, `dec_cnt`, `clr_cnt` and `trig_d` reset to 0.
- Decimation:
  - `extract_num` is latched into `dec_lat` on entry to CLEAR.
  - `dec_cnt` runs only in PRE, WAIT_TRIG and POST. It is cleared on entry to PRE.
  - Strobe `stb` fires when `dec_cnt`==`dec_lat`, and `dec_cnt` returns to 0 on that cycle; otherwise `dec_cnt` increments.
  - With `dec_lat`=0, `stb` fires every cycle.
- Trigger edge: `trig_d` <= `trig_sig` every cycle; `edge` = `trig_sig` & ~`trig_d`.
- IDLE:
  - `arm` → CLEAR.
  - `arm` is ignored in every other state.
- CLEAR:
  - `fifo_rst`=1 for `CLR_CYCLES` cycles, and `occ` is set to 0.
  - Afterwards → PRE, or → IDLE if CLEAR was entered by `abort`.
- PRE:
  - On `stb`: `fifo_wr_en`=1 and `occ`+1.
  - When `occ` reaches `PRE_DEPTH` → WAIT_TRIG.
  - Trigger inputs are ignored in PRE.
- WAIT_TRIG:
  - On `stb`: `fifo_wr_en`=1 and `fifo_rd_en`=1 in the same cycle, so `occ` is unchanged (sliding window). The popped data is discarded and `rd_valid` stays 0.
  - `edge` or `force_trig` → POST.
- POST:
  - On `stb`: `fifo_wr_en`=1 and `occ`+1.
  - When `occ` reaches `DEPTH`, or `fifo_full`=1 → READOUT. No write is issued while `fifo_full`=1.
- READOUT:
  - On `rd_req` with `occ`>0 and `fifo_empty`=0: `fifo_rd_en`=1 and `occ`−1.
  - `rd_req` when `occ`=0 is ignored.
  - When `occ` reaches 0 → pulse `done`, then → IDLE if `single_mode`=1, else → CLEAR (re-arm).
  - `single_mode` is sampled on the cycle `occ` reaches 0.
- `abort` in any non-IDLE state → CLEAR, marked as abort. Pending writes, reads and `rd_valid` are dropped. `abort` in IDLE is ignored. `abort` takes priority over a trigger in the same cycle.
- `fifo_wr_en` and `fifo_rd_en` are never both 1 outside WAIT_TRIG. Neither is 1 while `fifo_rst`=1.
- `occ` saturates: it never exceeds `DEPTH` and never underflows below 0.

## Timing

- `stb` in cycle N → `fifo_wr_en` high in cycle N+1, for exactly one cycle.
- Trigger:
  - `edge` or `force_trig` in cycle N → `state`=POST in cycle N+1.
  - A `stb` in cycle N is processed under WAIT_TRIG rules (slide).
  - The first post-trigger write is from the first `stb` after N.
- READOUT handshake:
  - `rd_req` in cycle N → `fifo_rd_en` in N+1 → `rd_valid` in N+2 (FIFO read latency 1).
  - Back-to-back `rd_req` gives one sample per cycle.
- `done` is asserted in the same cycle as `rd_valid` for the last sample.
- Asynchronous `rst` mid-operation: all outputs drop to 0 immediately. The FIFO is not cleared by this block until the next CLEAR.

## Test plan

Bench parameters: `DEPTH`=16, `PRE_DEPTH`=4.
- Basic capture, `extract_num`=0, `single_mode`=1: `arm` → `fifo_rst` high 4 cycles, 4 PRE writes, state 3, `trig_sig` rising → 12 POST writes, state 5. Then 16 `rd_req` → 16 `rd_valid`, `done` on the 16th, state 0.
- Decimation, `extract_num`=4: writes in PRE/POST are spaced exactly 5 cycles apart. Changing `extract_num` mid-acquisition has no effect until the next CLEAR.
- Sliding window: hold `trig_sig`=0 for 40 cycles in WAIT_TRIG → `fifo_wr_en` and `fifo_rd_en` are pulsed together on every write, `occ` stays 4, `rd_valid` stays 0.
- Trigger edge vs level: `trig_sig` already 1 on entry to WAIT_TRIG → no trigger until it falls and rises again. A `force_trig` pulse triggers immediately.
- Abort and re-arm: `abort` in POST → CLEAR with `fifo_rst` high 4 cycles → IDLE, `busy`=0. With `single_mode`=0, a completed readout → `done`, then state 1 on the next cycle.
- Boundaries: `rd_req` while `occ`=0 produces no `fifo_rd_en`. `fifo_full` forced high early in POST → READOUT with no further writes. Async `rst` asserted in PRE → all outputs 0 and state 0 without waiting for a clock edge.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: drives the adc_fifo strobes for one scope acquisition
// (clear, pre-trigger fill, sliding-window trigger wait, post fill, readout).
module capture_sequencer #(
  parameter int DEPTH      = 1024,
  parameter int PRE_DEPTH  = 256,
  parameter int OCC_W      = 11,
  parameter int CLR_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        abort,
  input  logic        single_mode,
  input  logic        trig_sig,
  input  logic        force_trig,
  input  logic [15:0] extract_num,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  input  logic        rd_req,
  output logic        fifo_wr_en,
  output logic        fifo_rd_en,
  output logic        fifo_rst,
  output logic        rd_valid,
  output logic        done,
  output logic        busy,
  output logic [2:0]  state
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [OCC_W-1:0] OCC_PRE  = OCC_W'(PRE_DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PRE   = 3'd2,
    S_WAIT  = 3'd3,
    S_POST  = 3'd4,
    S_READ  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [15:0]      dec_cnt_q, dec_cnt_d, dec_lat_q, dec_lat_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             trig_d_q, trig_d_d;
  logic             abt_q, abt_d;       // current CLEAR was entered by abort
  logic             fin_q, fin_d;       // last readout read issued this cycle
  logic             sm_q, sm_d;         // single_mode captured at last read
  logic             rd_pend_q, rd_pend_d;
  logic             wr_q, wr_d, rd_q, rd_d;
  logic             frst_q, frst_d, rv_q, rv_d, done_q, done_d, busy_q, busy_d;

  logic             run, stb, trig_edge, aborting, enter_clr;
  logic [OCC_W-1:0] occ_inc;

  // Next-state, counters and registered-strobe computation
  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    dec_cnt_d = dec_cnt_q;
    dec_lat_d = dec_lat_q;
    clr_cnt_d = clr_cnt_q;
    abt_d     = abt_q;
    sm_d      = sm_q;
    fin_d     = 1'b0;
    rd_pend_d = 1'b0;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    enter_clr = 1'b0;
    trig_d_d  = trig_sig;

    trig_edge = trig_sig & ~trig_d_q;
    occ_inc   = occ_q + OCC_W'(1);
    run       = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    stb       = run && (dec_cnt_q == dec_lat_q);
    aborting  = abort && (state_q != S_IDLE);

    if (run) dec_cnt_d = stb ? 16'd0 : dec_cnt_q + 16'd1;

    if (aborting) begin
      enter_clr = 1'b1;
      abt_d     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (arm) begin
          enter_clr = 1'b1;
          abt_d     = 1'b0;
        end
        S_CLEAR: begin
          occ_d = '0;
          if (clr_cnt_q == CLR_LAST) begin
            state_d   = abt_q ? S_IDLE : S_PRE;
            clr_cnt_d = '0;
            dec_cnt_d = 16'd0;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        S_PRE: if (stb) begin
          wr_d  = 1'b1;
          occ_d = occ_inc;
          if (occ_inc == OCC_PRE) state_d = S_WAIT;
        end
        S_WAIT: begin
          // push and pop together: window length stays at PRE_DEPTH
          if (stb) begin
            wr_d = 1'b1;
            rd_d = 1'b1;
          end
          if (trig_edge || force_trig) state_d = S_POST;
        end
        S_POST: begin
          if (fifo_full || (occ_q == OCC_FULL)) begin
            state_d = S_READ;
          end else if (stb) begin
            wr_d  = 1'b1;
            occ_d = occ_inc;
            if (occ_inc == OCC_FULL) state_d = S_READ;
          end
        end
        S_READ: begin
          // done_q marks the cycle the final sample is presented
          if (done_q) begin
            if (sm_q) state_d = S_IDLE;
            else begin
              enter_clr = 1'b1;
              abt_d     = 1'b0;
            end
          end else if (rd_req && (occ_q != '0) && !fifo_empty) begin
            rd_d      = 1'b1;
            rd_pend_d = 1'b1;
            occ_d     = occ_q - OCC_W'(1);
            if (occ_q == OCC_W'(1)) begin
              fin_d = 1'b1;
              sm_d  = single_mode;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (enter_clr) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
      occ_d     = '0;
      dec_lat_d = extract_num;
    end

    frst_d = (state_d == S_CLEAR);
    busy_d = (state_d != S_IDLE);
    rv_d   = rd_pend_q && !aborting;
    done_d = fin_q && !aborting;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      occ_q     <= '0;
      dec_cnt_q <= '0;
      dec_lat_q <= '0;
      clr_cnt_q <= '0;
      trig_d_q  <= 1'b0;
      abt_q     <= 1'b0;
      fin_q     <= 1'b0;
      sm_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      frst_q    <= 1'b0;
      rv_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      dec_cnt_q <= dec_cnt_d;
      dec_lat_q <= dec_lat_d;
      clr_cnt_q <= clr_cnt_d;
      trig_d_q  <= trig_d_d;
      abt_q     <= abt_d;
      fin_q     <= fin_d;
      sm_q      <= sm_d;
      rd_pend_q <= rd_pend_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      frst_q    <= frst_d;
      rv_q      <= rv_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_wr_en = wr_q;
  assign fifo_rd_en = rd_q;
  assign fifo_rst   = frst_q;
  assign rd_valid   = rv_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: cycle vector table, directed corner cases,
// and randomized acquisitions checked against an event-time model.
module tb_capture_sequencer;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0, single_mode = 1'b1;
  logic trig_sig = 1'b0, force_trig = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b0, rd_req = 1'b0;
  logic [15:0] extract_num = 16'd0;
  logic fifo_wr_en, fifo_rd_en, fifo_rst, rd_valid, done, busy;
  logic [2:0] state;
  logic [8:0] obs;

  capture_sequencer #(.DEPTH(DEPTH), .PRE_DEPTH(PRE), .OCC_W(5), .CLR_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .single_mode(single_mode),
    .trig_sig(trig_sig), .force_trig(force_trig), .extract_num(extract_num),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .rd_req(rd_req),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_rst(fifo_rst),
    .rd_valid(rd_valid), .done(done), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;
  assign obs = {state, fifo_wr_en, fifo_rd_en, fifo_rst, rd_valid, done, busy};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  bit rec = 0;
  int wr_q[$], rd_q[$], rv_q[$], dn_q[$];

  // event recorder, sampled mid-cycle
  always @(negedge clk) if (rec) begin
    if (fifo_wr_en) wr_q.push_back(cyc);
    if (fifo_rd_en) rd_q.push_back(cyc);
    if (rd_valid)   rv_q.push_back(cyc);
    if (done)       dn_q.push_back(cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
    int n = 0;
    while (state !== s && n < lim) begin tick(); n++; end
    chk(nm, int'(state), int'(s));
  endtask

  function automatic logic [8:0] ex(input logic [2:0] st, input logic wr, rd, fr, rv, dn, bz);
    return {st, wr, rd, fr, rv, dn, bz};
  endfunction

  typedef struct {
    logic       arm;
    logic       trig;
    logic       rdq;
    logic [8:0] exp;   // outputs expected in the following cycle
  } vec_t;
  vec_t vt[40];

  initial begin
    // basic capture, extract_num=0, single_mode=1
    for (int i = 0; i < 40; i++) begin
      vt[i].arm = 1'b0; vt[i].trig = 1'b0; vt[i].rdq = 1'b0; vt[i].exp = '0;
    end
    vt[0].arm = 1'b1;
    for (int i = 0; i < 4; i++) vt[i].exp = ex(3'd1, 0, 0, 1, 0, 0, 1);
    vt[4].exp = ex(3'd2, 0, 0, 0, 0, 0, 1);
    for (int i = 5; i < 8; i++) vt[i].exp = ex(3'd2, 1, 0, 0, 0, 0, 1);
    vt[8].exp = ex(3'd3, 1, 0, 0, 0, 0, 1);
    for (int i = 9; i < 22; i++) begin
      vt[i].trig = 1'b1;
      vt[i].exp  = ex(3'd4, 1, 0, 0, 0, 0, 1);
    end
    vt[9].exp  = ex(3'd4, 1, 1, 0, 0, 0, 1);
    vt[21].exp = ex(3'd5, 1, 0, 0, 0, 0, 1);
    for (int m = 0; m < 16; m++) begin
      vt[22+m].rdq = 1'b1;
      vt[22+m].exp = ex(3'd5, 0, 1, 0, (m >= 1), 0, 1);
    end
    vt[38].exp = ex(3'd5, 0, 0, 0, 1, 1, 1);
    vt[39].exp = ex(3'd0, 0, 0, 0, 0, 0, 0);

    // reset state
    tick(2);
    chk("reset_outs", int'(obs), 0);
    rst = 1'b0;
    tick();
    chk("post_reset_idle", int'(obs), 0);

    for (int i = 0; i < 40; i++) begin
      arm = vt[i].arm; trig_sig = vt[i].trig; rd_req = vt[i].rdq;
      tick();
      chk($sformatf("vec[%0d]", i), int'(obs), int'(vt[i].exp));
    end
    arm = 0; trig_sig = 0; rd_req = 0;
    tick(2);

    // level-high trigger must not fire until a fresh rising edge; then abort in POST
    trig_sig = 1; tick();
    arm = 1; tick(); arm = 0;
    wait_state(3'd3, 60, "lvl_reach_wait");
    tick(10);
    chk("lvl_no_trig", int'(state), 3);
    trig_sig = 0; tick();
    trig_sig = 1; tick();
    chk("lvl_retrig", int'(state), 4);
    abort = 1; tick(); abort = 0; trig_sig = 0;
    chk("abort_to_clear", int'(state), 1);
    begin
      int c = 0;
      repeat (8) begin if (fifo_rst) c++; tick(); end
      chk("abort_rst_len", c, 4);
    end
    chk("abort_idle", int'(state), 0);
    chk("abort_busy", int'(busy), 0);

    // force trigger, early fifo_full, empty/occ=0 reads, auto re-arm
    single_mode = 0;
    arm = 1; tick(); arm = 0;
    wait_state(3'd3, 60, "frc_reach_wait");
    tick(3);
    force_trig = 1; tick(); force_trig = 0;
    chk("force_trig", int'(state), 4);
    tick(3);
    fifo_full = 1; tick();
    chk("full_readout", int'(state), 5);
    begin
      int c = 0;
      repeat (4) begin if (fifo_wr_en) c++; tick(); end
      chk("full_no_wr", c, 0);
    end
    fifo_full = 0;
    fifo_empty = 1; rd_req = 1; tick(3);
    chk("empty_no_rd", int'(fifo_rd_en), 0);
    fifo_empty = 0;
    begin
      int n = 0;
      while (!done && n < 60) begin tick(); n++; end
    end
    chk("sm0_done", int'(done), 1);
    chk("done_with_valid", int'(rd_valid), 1);
    chk("occ0_no_rd", int'(fifo_rd_en), 0);
    rd_req = 0; tick();
    chk("rearm_clear", int'(state), 1);
    abort = 1; tick(); abort = 0;
    tick(5);
    chk("abort_in_clear_idle", int'(state), 0);
    single_mode = 1;

    // asynchronous reset in PRE
    arm = 1; tick(); arm = 0;
    wait_state(3'd2, 20, "arst_reach_pre");
    #2 rst = 1;
    #1 chk("arst_outs", int'(obs), 0);
    tick(); rst = 0; tick();

    // randomized acquisitions against an event-time model
    for (int t = 0; t < 6; t++) begin
      int k, d, a, s3, tt, nsl, l, sl, n, bad;
      bit got;
      k = $urandom_range(0, 4);
      d = (t == 0) ? 40 : $urandom_range(0, 20);
      wr_q.delete(); rd_q.delete(); rv_q.delete(); dn_q.delete();
      rec = 1;
      extract_num = 16'(k);
      arm = 1; a = cyc; tick(); arm = 0;
      // stb i falls in cycle a+5+k+i*(k+1); its write shows one cycle later
      s3  = a + 5 + k + 3 * (k + 1);
      tt  = s3 + 1 + d;
      nsl = (tt - s3) / (k + 1);
      l   = 15 + nsl;
      sl  = a + 5 + k + l * (k + 1);
      n = 0; got = 0;
      while (!got && n < 600) begin
        if (cyc == a + 8) extract_num = 16'($urandom);
        trig_sig = (cyc >= tt);
        rd_req   = (cyc > sl) ? ($urandom_range(0, 2) != 0) : 1'b0;
        tick(); n++;
        if (done) got = 1;
      end
      rd_req = 0; trig_sig = 0;
      tick(2);
      rec = 0;
      chk($sformatf("rt%0d_done", t), int'(got), 1);
      chk($sformatf("rt%0d_idle", t), int'(state), 0);
      chk($sformatf("rt%0d_nwr", t), wr_q.size(), l + 1);
      bad = 0;
      foreach (wr_q[i]) if (i <= l && wr_q[i] != a + 6 + k + i * (k + 1)) bad++;
      chk($sformatf("rt%0d_wr_times", t), bad, 0);
      chk($sformatf("rt%0d_nrd", t), rd_q.size(), nsl + 16);
      bad = 0;
      for (int i = 0; i < nsl; i++)
        if (i >= rd_q.size() || rd_q[i] != a + 6 + k + (4 + i) * (k + 1)) bad++;
      chk($sformatf("rt%0d_slide_times", t), bad, 0);
      chk($sformatf("rt%0d_nrv", t), rv_q.size(), 16);
      bad = 0;
      for (int j = 0; j < 16; j++)
        if (j >= rv_q.size() || nsl + j >= rd_q.size() || rv_q[j] != rd_q[nsl+j] + 1) bad++;
      chk($sformatf("rt%0d_rv_latency", t), bad, 0);
      chk($sformatf("rt%0d_ndone", t), dn_q.size(), 1);
      chk($sformatf("rt%0d_done_at_last", t),
          (dn_q.size() > 0) ? dn_q[0] : -1, (rv_q.size() > 0) ? rv_q[rv_q.size()-1] : -2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
